// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: load/store stage between EX and the shared data memory.
// Accepts one instruction at a time from EX, issues at most one memory access,
// and returns a single write-back beat (with error flags) before accepting again.
module mem_stage_lsu #(
   parameter int TIMEOUT = 16,
   parameter int ADDR_W  = 32
) (
   input  logic              clk,
   input  logic              reset,
   // EX side
   input  logic              i_ex_valid,
   output logic              o_ex_ready,
   input  logic              i_ex_load,
   input  logic              i_ex_store,
   input  logic [2:0]        i_ex_funct3,
   input  logic [ADDR_W-1:0] i_ex_addr,
   input  logic [31:0]       i_ex_wdata,
   input  logic [4:0]        i_ex_rd,
   input  logic              i_ex_regwrite,
   // memory side
   output logic [1:0]        o_mem_ctrl,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [3:0]        o_mem_be,
   output logic [31:0]       o_mem_wdata,
   input  logic [31:0]       i_mem_rdata,
   input  logic              i_mem_ack,
   // write-back side
   output logic              o_wb_valid,
   output logic              o_wb_write,
   output logic [4:0]        o_wb_rd,
   output logic [31:0]       o_wb_data,
   output logic              o_err_misalign,
   output logic              o_err_timeout
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [4:0]        r_rd;
   logic              r_regwrite;
   logic              r_is_store;
   logic [2:0]        r_funct3;
   logic [1:0]        r_lane;
   logic [1:0]        r_mem_ctrl;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [3:0]        r_mem_be;
   logic [31:0]       r_mem_wdata;
   logic              r_wb_valid;
   logic              r_wb_write;
   logic [31:0]       r_wb_data;
   logic              r_err_misalign;
   logic              r_err_timeout;

   logic              w_accept;
   logic              w_is_mem;
   logic [1:0]        w_size;
   logic              w_misalign;
   logic [3:0]        w_be;
   logic [31:0]       w_wdata;
   logic [7:0]        w_rd_byte [4];
   logic [7:0]        w_sel_byte;
   logic [15:0]       w_sel_half;
   logic [31:0]       w_load_data;

   assign o_ex_ready = (r_state == S_IDLE) && !reset;
   assign w_accept   = i_ex_valid && o_ex_ready;
   // A load+store combination is treated as a store; either flag makes it a memory op.
   assign w_is_mem   = i_ex_load || i_ex_store;
   // funct3[1:0]: 00 byte, 01 half, 1x word.
   assign w_size     = i_ex_funct3[1:0];
   assign w_misalign = ((w_size == 2'b01) && i_ex_addr[0]) ||
                       (w_size[1] && (i_ex_addr[1:0] != 2'b00));

   // Split the read word into byte lanes (little-endian).
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_lane
         assign w_rd_byte[gi] = i_mem_rdata[8*gi +: 8];
      end
   endgenerate

   assign w_sel_byte = w_rd_byte[r_lane];
   assign w_sel_half = r_lane[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];

   // Store byte enables and lane-replicated store data for the incoming instruction.
   always_comb begin
      w_be    = 4'b0000;
      w_wdata = 32'h0;
      case (w_size)
         2'b00: begin
            w_be    = 4'b0001 << i_ex_addr[1:0];
            w_wdata = {4{i_ex_wdata[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << i_ex_addr[1:0];
            w_wdata = {2{i_ex_wdata[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = i_ex_wdata;
         end
      endcase
   end

   // Align and zero/sign-extend the returned word for the latched load type.
   always_comb begin
      w_load_data = i_mem_rdata;
      case (r_funct3)
         3'b000:  w_load_data = {{24{w_sel_byte[7]}}, w_sel_byte};
         3'b100:  w_load_data = {24'h0, w_sel_byte};
         3'b001:  w_load_data = {{16{w_sel_half[15]}}, w_sel_half};
         3'b101:  w_load_data = {16'h0, w_sel_half};
         default: w_load_data = i_mem_rdata;
      endcase
   end

   // Control FSM with all memory and write-back outputs registered.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= '0;
         r_rd           <= '0;
         r_regwrite     <= 1'b0;
         r_is_store     <= 1'b0;
         r_funct3       <= '0;
         r_lane         <= '0;
         r_mem_ctrl     <= 2'b00;
         r_mem_addr     <= '0;
         r_mem_be       <= '0;
         r_mem_wdata    <= '0;
         r_wb_valid     <= 1'b0;
         r_wb_write     <= 1'b0;
         r_wb_data      <= '0;
         r_err_misalign <= 1'b0;
         r_err_timeout  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_rd       <= i_ex_rd;
                  r_regwrite <= i_ex_regwrite;
                  r_is_store <= i_ex_store;
                  r_funct3   <= i_ex_funct3;
                  r_lane     <= i_ex_addr[1:0];
                  if (!w_is_mem) begin
                     r_state    <= S_DONE;
                     r_wb_valid <= 1'b1;
                     r_wb_write <= i_ex_regwrite && (i_ex_rd != 5'd0);
                     r_wb_data  <= 32'(i_ex_addr);
                  end else if (w_misalign) begin
                     // Misaligned: report immediately, never touch memory.
                     r_state        <= S_DONE;
                     r_wb_valid     <= 1'b1;
                     r_wb_write     <= 1'b0;
                     r_wb_data      <= 32'h0;
                     r_err_misalign <= 1'b1;
                  end else begin
                     r_state     <= S_ACCESS;
                     r_cnt       <= '0;
                     r_mem_ctrl  <= i_ex_store ? 2'b01 : 2'b10;
                     r_mem_addr  <= {i_ex_addr[ADDR_W-1:2], 2'b00};
                     r_mem_be    <= i_ex_store ? w_be : 4'b0000;
                     r_mem_wdata <= i_ex_store ? w_wdata : 32'h0;
                  end
               end
            end
            S_ACCESS: begin
               // Ack is checked first so it wins over a simultaneous timeout.
               if (i_mem_ack) begin
                  r_state    <= S_DONE;
                  r_mem_ctrl <= 2'b00;
                  r_wb_valid <= 1'b1;
                  r_wb_write <= !r_is_store && r_regwrite && (r_rd != 5'd0);
                  r_wb_data  <= r_is_store ? 32'h0 : w_load_data;
               end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                  r_state       <= S_DONE;
                  r_mem_ctrl    <= 2'b00;
                  r_wb_valid    <= 1'b1;
                  r_wb_write    <= 1'b0;
                  r_wb_data     <= 32'h0;
                  r_err_timeout <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_state        <= S_IDLE;
               r_wb_valid     <= 1'b0;
               r_wb_write     <= 1'b0;
               r_err_misalign <= 1'b0;
               r_err_timeout  <= 1'b0;
            end
            default: begin
               r_state    <= S_IDLE;
               r_mem_ctrl <= 2'b00;
               r_wb_valid <= 1'b0;
            end
         endcase
      end
   end

   assign o_mem_ctrl     = r_mem_ctrl;
   assign o_mem_addr     = r_mem_addr;
   assign o_mem_be       = r_mem_be;
   assign o_mem_wdata    = r_mem_wdata;
   assign o_wb_valid     = r_wb_valid;
   assign o_wb_write     = r_wb_write;
   assign o_wb_rd        = r_rd;
   assign o_wb_data      = r_wb_data;
   assign o_err_misalign = r_err_misalign;
   assign o_err_timeout  = r_err_timeout;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// transactions checked cycle by cycle against a transaction-level model.
module tb_mem_stage_lsu;

   localparam int TIMEOUT = 16;
   localparam int ADDR_W  = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              ex_valid, ex_ready, ex_load, ex_store, ex_regwrite;
   logic [2:0]        ex_funct3;
   logic [ADDR_W-1:0] ex_addr;
   logic [31:0]       ex_wdata;
   logic [4:0]        ex_rd;
   logic [1:0]        mem_ctrl;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        mem_be;
   logic [31:0]       mem_wdata, mem_rdata;
   logic              mem_ack;
   logic              wb_valid, wb_write, err_misalign, err_timeout;
   logic [4:0]        wb_rd;
   logic [31:0]       wb_data;

   int n_checks = 0;
   int n_errors = 0;
   int n_txn    = 0;

   mem_stage_lsu #(.TIMEOUT(TIMEOUT), .ADDR_W(ADDR_W)) dut (
      .clk            (clk),
      .reset          (reset),
      .i_ex_valid     (ex_valid),
      .o_ex_ready     (ex_ready),
      .i_ex_load      (ex_load),
      .i_ex_store     (ex_store),
      .i_ex_funct3    (ex_funct3),
      .i_ex_addr      (ex_addr),
      .i_ex_wdata     (ex_wdata),
      .i_ex_rd        (ex_rd),
      .i_ex_regwrite  (ex_regwrite),
      .o_mem_ctrl     (mem_ctrl),
      .o_mem_addr     (mem_addr),
      .o_mem_be       (mem_be),
      .o_mem_wdata    (mem_wdata),
      .i_mem_rdata    (mem_rdata),
      .i_mem_ack      (mem_ack),
      .o_wb_valid     (wb_valid),
      .o_wb_write     (wb_write),
      .o_wb_rd        (wb_rd),
      .o_wb_data      (wb_data),
      .o_err_misalign (err_misalign),
      .o_err_timeout  (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: byte count of an access from funct3.
   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   // Reference: byte enables are the bytes covered by [lane, lane+n).
   function automatic logic [3:0] ref_be(input int lane, input int n);
      logic [3:0] be = 4'b0000;
      for (int b = 0; b < 4; b++) be[b] = (b >= lane) && (b < lane + n);
      return be;
   endfunction

   // Reference: every byte lane carries the store datum byte (lane mod size).
   function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int n);
      logic [31:0] w = 32'h0;
      for (int b = 0; b < 4; b++) w[8*b +: 8] = d[8*(b % n) +: 8];
      return w;
   endfunction

   // Reference: extract n bytes at lane and extend by arithmetic.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int lane,
                                            input int n, input bit sgn);
      longint v;
      longint span;
      span = longint'(1) << (8 * n);
      v = (longint'(rdata) >> (8 * lane)) % span;
      if (sgn && v >= span / 2) v = v - span;
      return v[31:0];
   endfunction

   // Drive one instruction and check it cycle by cycle; called and returns at a negedge.
   // ack_k: index of the ACCESS cycle carrying mem_ack; >= TIMEOUT means no ack at all.
   task automatic run_txn(input bit is_load, input bit is_store, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [4:0] rd, input bit rw, input logic [31:0] rdata,
                          input int ack_k);
      bit          is_mem, mis, acked, err;
      int          n, lane, cycles;
      logic [31:0] exp_data;
      logic [1:0]  exp_ctrl;
      is_mem = is_load || is_store;
      n      = nbytes(f3);
      lane   = int'(addr[1:0]);
      mis    = is_mem && ((addr % n) != 0);
      acked  = (ack_k < TIMEOUT);
      cycles = (is_mem && !mis) ? (acked ? ack_k + 1 : TIMEOUT) : 0;
      err    = mis || (is_mem && !mis && !acked);
      exp_ctrl = is_store ? 2'b01 : 2'b10;
      if (!is_mem)       exp_data = addr;
      else if (is_store) exp_data = 32'h0;
      else               exp_data = ref_load(rdata, lane, n, !f3[2]);

      chk("ready_idle", 32'(ex_ready), 32'd1);
      ex_valid = 1'b1; ex_load = is_load; ex_store = is_store; ex_funct3 = f3;
      ex_addr = addr; ex_wdata = wdata; ex_rd = rd; ex_regwrite = rw;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0;
      ex_load = $urandom_range(0, 1); ex_store = $urandom_range(0, 1);
      ex_addr = $urandom;

      for (int k = 0; k < cycles; k++) begin
         chk("acc_ctrl", 32'(mem_ctrl), 32'(exp_ctrl));
         chk("acc_addr", mem_addr, {addr[31:2], 2'b00});
         if (is_store) begin
            chk("acc_be", 32'(mem_be), 32'(ref_be(lane, n)));
            chk("acc_wdata", mem_wdata, ref_wdata(wdata, n));
         end
         chk("acc_ready", 32'(ex_ready), 32'd0);
         chk("acc_wbv", 32'(wb_valid), 32'd0);
         mem_rdata = (k == ack_k) ? rdata : $urandom;
         mem_ack   = (k == ack_k);
         @(posedge clk);
         @(negedge clk);
         mem_ack = 1'b0;
      end

      // Write-back beat.
      chk("wb_valid", 32'(wb_valid), 32'd1);
      chk("wb_write", 32'(wb_write), 32'((rw && rd != 5'd0 && !err && !is_store) ? 1 : 0));
      chk("wb_rd", 32'(wb_rd), 32'(rd));
      if (!err) chk("wb_data", wb_data, exp_data);
      chk("err_mis", 32'(err_misalign), 32'(mis));
      chk("err_to", 32'(err_timeout), 32'(is_mem && !mis && !acked));
      chk("done_ctrl", 32'(mem_ctrl), 32'd0);
      chk("done_ready", 32'(ex_ready), 32'd0);
      mem_ack = $urandom_range(0, 1);   // stray ack outside ACCESS must be ignored
      @(posedge clk);
      @(negedge clk);
      mem_ack = 1'b0;
      chk("post_wbv", 32'(wb_valid), 32'd0);
      chk("post_err", 32'({err_misalign, err_timeout}), 32'd0);
      chk("post_ctrl", 32'(mem_ctrl), 32'd0);
      n_txn++;
      $display("txn %0d: ld=%0d st=%0d f3=%0d addr=%h rd=%0d acc_cycles=%0d wb_data=%h err=%0d",
               n_txn, is_load, is_store, f3, addr, rd, cycles, wb_data, err);
   endtask

   initial begin
      logic [2:0] f3_ld_tbl [5];
      logic [2:0] f3;
      int         kind, ack_k;
      bit         ld, st;
      f3_ld_tbl[0] = 3'b000; f3_ld_tbl[1] = 3'b001; f3_ld_tbl[2] = 3'b010;
      f3_ld_tbl[3] = 3'b100; f3_ld_tbl[4] = 3'b101;

      reset = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b0;
      ex_addr = '0; ex_wdata = '0; ex_rd = '0; ex_regwrite = 1'b0;
      mem_rdata = '0; mem_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", 32'(mem_ctrl), 32'd0);
      chk("rst_wbv", 32'(wb_valid), 32'd0);
      chk("rst_wbw", 32'(wb_write), 32'd0);
      chk("rst_err", 32'({err_misalign, err_timeout}), 32'd0);
      chk("rst_ready", 32'(ex_ready), 32'd0);
      chk("rst_wbdata", wb_data, 32'd0);
      reset = 1'b0;
      #1;
      chk("rel_ready", 32'(ex_ready), 32'd1);
      @(negedge clk);

      // Directed scenarios.
      run_txn(0, 0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1, 32'h0, 0);
      run_txn(1, 0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h80FF_0000, 1);
      run_txn(1, 0, 3'b100, 32'h0000_0103, 32'h0, 5'd7, 1, 32'h80FF_0000, 1);
      run_txn(0, 1, 3'b001, 32'h0000_0102, 32'hAAAA_BEEF, 5'd9, 1, 32'h0, 0);
      run_txn(1, 0, 3'b010, 32'h0000_0102, 32'h0, 5'd3, 1, 32'h0, 0);
      run_txn(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd4, 1, 32'h1234_5678, TIMEOUT);
      run_txn(1, 0, 3'b010, 32'h0000_0200, 32'h0, 5'd4, 1, 32'h1234_5678, TIMEOUT - 1);
      run_txn(1, 1, 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 5'd6, 1, 32'h0, 0);

      // Reset in the second ACCESS cycle of a store.
      ex_valid = 1'b1; ex_load = 1'b0; ex_store = 1'b1; ex_funct3 = 3'b010;
      ex_addr = 32'h0000_0400; ex_wdata = 32'h1111_2222; ex_rd = 5'd8; ex_regwrite = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ex_valid = 1'b0;
      chk("rs_acc0_ctrl", 32'(mem_ctrl), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("rs_acc1_ctrl", 32'(mem_ctrl), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("rs_ctrl", 32'(mem_ctrl), 32'd0);
      chk("rs_wbv", 32'(wb_valid), 32'd0);
      chk("rs_ready_in_rst", 32'(ex_ready), 32'd0);
      reset = 1'b0;
      #1;
      chk("rs_ready", 32'(ex_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("rs_wbv2", 32'(wb_valid), 32'd0);
      chk("rs_ctrl2", 32'(mem_ctrl), 32'd0);
      $display("txn reset-in-access: store 0x400 aborted");

      // Randomized transactions.
      for (int i = 0; i < 250; i++) begin
         kind = $urandom_range(0, 2);
         ld = (kind == 1);
         st = (kind == 2);
         if (st && $urandom_range(0, 7) == 0) ld = 1'b1;
         if (st) f3 = 3'($urandom_range(0, 2));
         else    f3 = f3_ld_tbl[$urandom_range(0, 4)];
         case ($urandom_range(0, 9))
            0:       ack_k = TIMEOUT;
            1:       ack_k = TIMEOUT - 1;
            default: ack_k = $urandom_range(0, 4);
         endcase
         run_txn(ld, st, f3, $urandom, $urandom, 5'($urandom_range(0, 31)),
                 bit'($urandom_range(0, 1)), $urandom, ack_k);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Load/store stage between the execute stage and the shared data memory of the RISC-V 32-bit core.
- Registers the EX result and issues memory reads/writes using the core's 2-bit control encoding: bit1 = read, bit0 = write, never both.
- Waits for a memory acknowledge, aligns and sign-extends load data, and presents a one-cycle write-back beat to the register-file write port.
- Stalls EX through a valid/ready handshake while an access is outstanding.

Parameters:
- TIMEOUT, 16: cycles to wait for mem_ack before aborting the access with an error.
- ADDR_W, 32: width of the byte address.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  EX presents an instruction
- ex_ready  out  1  stage can accept; transfer occurs when ex_valid && ex_ready at a rising edge
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store (ex_load && ex_store is illegal and is treated as a store)
- ex_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010
- ex_addr  in  ADDR_W  byte address, or the ALU result for non-memory ops
- ex_wdata  in  32  store data (rs2)
- ex_rd  in  5  destination register
- ex_regwrite  in  1  instruction writes rd
- mem_ctrl  out  2  [1] read, [0] write
- mem_addr  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
- mem_be  out  4  byte enables for stores
- mem_wdata  out  32  store data shifted to byte lanes
- mem_rdata  in  32  little-endian read word
- mem_ack  in  1  memory completed the current access
- wb_valid  out  1  one-cycle write-back beat
- wb_write  out  1  write rd (0 for stores, errors, or rd==0)
- wb_rd  out  5  destination register
- wb_data  out  32  write-back value
- err_misalign  out  1  pulses with wb_valid on a misaligned access
- err_timeout  out  1  pulses with wb_valid on an ack timeout

Behaviour:
- States: IDLE, ACCESS, DONE. Reset forces IDLE; all outputs and counters go to 0. Reset mid-ACCESS drops mem_ctrl to 00 on the next edge, with no write-back.
- ex_ready = 1 only in IDLE and not in reset.
- IDLE, accepted non-memory op: latch rd/regwrite/addr, go to DONE, wb_data = ex_addr. Latency is 1 cycle.
- IDLE, accepted load/store, misaligned (halfword with addr[0]=1, or word with addr[1:0]≠0): go to DONE with err_misalign=1, wb_write=0. No memory access is issued.
- IDLE, accepted aligned load/store: go to ACCESS.
  - Load: mem_ctrl=10.
  - Store: mem_ctrl=01, mem_be = 0001/0011/1111 shifted left by addr[1:0], mem_wdata = ex_wdata replicated per size into lanes (byte ×4, half ×2).
  - mem_ctrl, mem_addr, mem_be and mem_wdata are registered and held constant for the whole of ACCESS.
- ACCESS: the timeout counter starts at 0 on entry and increments each cycle.
  - mem_ack sampled high: for loads, capture the lane selected by addr[1:0] and zero- or sign-extend per funct3 into wb_data. mem_ctrl goes to 00 and the FSM moves to DONE.
  - Counter reaches TIMEOUT-1 without ack: mem_ctrl goes to 00, go to DONE with err_timeout=1, wb_write=0.
  - mem_ack in the same cycle as the timeout: ack wins.
- DONE: wb_valid=1 for exactly one cycle, then IDLE.
  - wb_write = regwrite && rd≠0 && no error && not a store.
  - Store wb_data = 0.
- Minimum throughput: non-memory op every 2 cycles; a memory op with ack in its first ACCESS cycle completes in 3 cycles.
- mem_ack while not in ACCESS is ignored.
- mem_ctrl is never 11.

Test Plan:
- Non-memory op: ex_addr=0x1234, rd=5, regwrite=1 → wb_valid one cycle later with wb_data=0x1234, wb_write=1. ex_ready is 0 in the DONE cycle.
- LB at addr 0x103, mem_rdata=0x80FF_0000, ack after 2 cycles → mem_ctrl=10 and mem_addr=0x100 held for 2 cycles; wb_data=0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH at addr 0x102, wdata=0xAAAA_BEEF → mem_ctrl=01, mem_be=1100, mem_wdata=0xBEEFBEEF; wb_write=0.
- LW at addr 0x102 → no mem_ctrl activity, err_misalign=1 with wb_valid, wb_write=0.
- Load with no ack, TIMEOUT=16 → mem_ctrl=10 for exactly 16 cycles, then err_timeout pulse and return to IDLE. Repeat with ack on cycle 16 → normal completion, no error.
- Reset asserted in the 2nd ACCESS cycle of a store → mem_ctrl=00 after the next edge, no wb_valid, ex_ready=1 once reset deasserts.
